spi_host_master: RTL and testbench

Single-clock SPI master that generates 16-bit frames for the sensor-register SPI slave. It sits between on-chip control logic and the slave's `spi_clk`/`mosi`/`miso`/`csb`/`ldb` pins, and serialises one command per valid/ready handshake. It runs three kinds of operation:
- register write;
- register read, which returns the 11-bit readback;
- standalone LDB load pulse, which latches the sensor snapshot.

---
 rtl/spi_host_master.sv | 155 +++++++++++++++
 tb/tb_spi_host_master.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_host_master.sv
// spi_host_master: 16-bit SPI frame master (CPOL=0) for the sensor-register
// slave. Carries out register writes, register reads with 11-bit readback,
// and standalone LDB load pulses. Accepts one operation per handshake.
module spi_host_master #(
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned CS_SETUP  = 2,
    parameter int unsigned CS_HOLD   = 2,
    parameter int unsigned CS_IDLE   = 4,
    parameter int unsigned LDB_WIDTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rw,
    input  logic [3:0]  cmd_addr,
    input  logic [10:0] cmd_wdata,
    input  logic        ldb_valid,
    output logic        done,
    output logic [10:0] rdata,
    output logic        sclk,
    output logic        mosi,
    input  logic        miso,
    output logic        csb,
    output logic        ldb
);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, LOAD, GAP} state_t;

    localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
    localparam logic [15:0] BIT_LAST   = 16'(2 * CLK_DIV - 1);
    localparam logic [15:0] SCLK_HIGH  = 16'(CLK_DIV);
    localparam logic [15:0] HOLD_LAST  = 16'(CS_HOLD - 1);
    localparam logic [15:0] LOAD_LAST  = 16'(LDB_WIDTH + 1);
    localparam logic [15:0] LDB_LAST   = 16'(LDB_WIDTH);
    localparam logic [15:0] GAP_LAST   = 16'(CS_IDLE - 1);

    state_t      state, state_d;
    logic [15:0] cnt, cnt_d;
    logic [3:0]  bit_idx, bit_d;
    logic [15:0] frame, frame_d;
    logic [10:0] rx, rx_d;

    logic        csb_d, ldb_d, sclk_d, mosi_d, done_d;
    logic [10:0] rdata_d;

    assign cmd_ready = (state == IDLE);

    // State register plus per-state cycle counter, bit index, frame and receive shifter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            frame   <= '0;
            rx      <= '0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            bit_idx <= bit_d;
            frame   <= frame_d;
            rx      <= rx_d;
        end
    end

    // Next-state logic: sequence SETUP/SHIFT/HOLD or LOAD, always followed by GAP
    always_comb begin
        state_d = state;
        cnt_d   = cnt + 16'd1;
        bit_d   = bit_idx;
        frame_d = frame;
        case (state)
            IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (ldb_valid) begin
                    state_d = LOAD;
                end else if (cmd_valid) begin
                    state_d = SETUP;
                    frame_d = {cmd_rw, cmd_addr, cmd_rw ? 11'd0 : cmd_wdata};
                end
            end
            SETUP: begin
                if (cnt == SETUP_LAST) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                if (cnt == BIT_LAST) begin
                    cnt_d = '0;
                    if (bit_idx == 4'd15) begin
                        state_d = HOLD;
                    end else begin
                        bit_d = bit_idx + 4'd1;
                    end
                end
            end
            HOLD: begin
                if (cnt == HOLD_LAST) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                if (cnt == LOAD_LAST) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode from the upcoming state so every pin is a plain register;
    // MISO is taken in the cycle where the registered SCLK is high for the first time
    always_comb begin
        csb_d   = !(state_d inside {SETUP, SHIFT, HOLD, LOAD});
        sclk_d  = (state_d == SHIFT) && (cnt_d >= SCLK_HIGH);
        mosi_d  = (state_d inside {SETUP, SHIFT, HOLD}) ? frame_d[4'd15 - bit_d] : 1'b0;
        ldb_d   = !((state_d == LOAD) && (cnt_d >= 16'd1) && (cnt_d <= LDB_LAST));
        done_d  = ((state == HOLD) || (state == LOAD)) && (state_d == GAP);
        rx_d    = ((state == SHIFT) && (cnt == SCLK_HIGH)) ? {rx[9:0], miso} : rx;
        rdata_d = ((state == HOLD) && (state_d == GAP) && frame[15]) ? rx : rdata;
    end

    // Output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csb   <= 1'b1;
            ldb   <= 1'b1;
            sclk  <= 1'b0;
            mosi  <= 1'b0;
            done  <= 1'b0;
            rdata <= '0;
        end else begin
            csb   <= csb_d;
            ldb   <= ldb_d;
            sclk  <= sclk_d;
            mosi  <= mosi_d;
            done  <= done_d;
            rdata <= rdata_d;
        end
    end

endmodule

// File: tb/tb_spi_host_master.sv
// tb_spi_host_master: scoreboard bench for spi_host_master. Instance 0 uses
// default timing, instance 1 the fastest timing (all parameters 1 except LDB_WIDTH).
module tb_spi_host_master;

    typedef struct {
        logic [15:0] frame;
        logic [10:0] rdata;
        int unsigned t0;
        int unsigned lat;
        bit          is_ldb;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned cyc = 0;

    logic        cmd_valid_s [2];
    logic        cmd_ready_s [2];
    logic        cmd_rw_s    [2];
    logic [3:0]  cmd_addr_s  [2];
    logic [10:0] cmd_wdata_s [2];
    logic        ldb_valid_s [2];
    logic        done_s      [2];
    logic [10:0] rdata_s     [2];
    logic        sclk_s      [2];
    logic        mosi_s      [2];
    logic        csb_s       [2];
    logic        ldb_s       [2];
    logic [10:0] slave_w     [2];
    int unsigned dones       [2];

    exp_t q [2][$];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input int d, input string name,
                                input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL dut%0d %s: got 0x%0h expected 0x%0h", d, name, act, exp);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int unsigned PERIOD = (g == 0) ? 4 : 2;

        logic        miso_l = 1'b0;
        logic [3:0]  k = '0;
        logic        sclk_slv_p = 1'b0;
        logic [15:0] sh = '0;
        int unsigned rises = 0, ldb_low = 0, csb_fall = 0, last_rise = 0;
        int unsigned gmin = 32'hFFFF, gmax = 0;
        bit          ldb_outside = 0;
        logic        csb_p = 1'b1, sclk_p = 1'b0;
        exp_t        e;

        spi_host_master #(
            .CLK_DIV   ((g == 0) ? 2 : 1),
            .CS_SETUP  ((g == 0) ? 2 : 1),
            .CS_HOLD   ((g == 0) ? 2 : 1),
            .CS_IDLE   ((g == 0) ? 4 : 1),
            .LDB_WIDTH (2)
        ) dut (
            .clk       (clk),
            .rst       (rst),
            .cmd_valid (cmd_valid_s[g]),
            .cmd_ready (cmd_ready_s[g]),
            .cmd_rw    (cmd_rw_s[g]),
            .cmd_addr  (cmd_addr_s[g]),
            .cmd_wdata (cmd_wdata_s[g]),
            .ldb_valid (ldb_valid_s[g]),
            .done      (done_s[g]),
            .rdata     (rdata_s[g]),
            .sclk      (sclk_s[g]),
            .mosi      (mosi_s[g]),
            .miso      (miso_l),
            .csb       (csb_s[g]),
            .ldb       (ldb_s[g])
        );

        // Slave model: shifts out its word on bits 5..15, changing on SCLK falling edges
        always @(negedge clk) begin
            if (csb_s[g]) k = '0;
            else if (sclk_slv_p && !sclk_s[g]) k = k + 4'd1;
            sclk_slv_p = sclk_s[g];
            miso_l = (k >= 4'd5) ? slave_w[g][4'd15 - k] : 1'b0;
        end

        // Monitor: records pin activity and checks each completed operation against the queue
        always @(negedge clk) begin
            if (rst) begin
                csb_p  = 1'b1;
                sclk_p = 1'b0;
            end else begin
                if (csb_p && !csb_s[g]) begin
                    csb_fall = cyc; sh = '0; rises = 0; ldb_low = 0;
                    ldb_outside = 0; gmin = 32'hFFFF; gmax = 0;
                end
                if (!csb_s[g] && sclk_s[g] && !sclk_p) begin
                    sh = {sh[14:0], mosi_s[g]};
                    if (rises > 0) begin
                        if (cyc - last_rise < gmin) gmin = cyc - last_rise;
                        if (cyc - last_rise > gmax) gmax = cyc - last_rise;
                    end
                    last_rise = cyc;
                    rises++;
                end
                if (!ldb_s[g]) begin
                    if (csb_s[g]) ldb_outside = 1;
                    else ldb_low++;
                end
                if (done_s[g]) begin
                    dones[g]++;
                    if (q[g].size() == 0) begin
                        chk(g, "unexpected_done", done_s[g], 0);
                    end else begin
                        e = q[g].pop_front();
                        chk(g, "done_cycle", cyc, e.t0 + e.lat);
                        chk(g, "csb_fall_cycle", csb_fall, e.t0 + 1);
                        chk(g, "csb_high_at_done", csb_s[g], 1);
                        chk(g, "rdata", rdata_s[g], e.rdata);
                        if (e.is_ldb) begin
                            chk(g, "ldb_low_cycles", ldb_low, 2);
                            chk(g, "ldb_outside_csb", ldb_outside, 0);
                            chk(g, "ldb_sclk_rises", rises, 0);
                        end else begin
                            chk(g, "frame", sh, e.frame);
                            chk(g, "sclk_rises", rises, 16);
                            chk(g, "sclk_period_min", gmin, PERIOD);
                            chk(g, "sclk_period_max", gmax, PERIOD);
                        end
                    end
                end
                csb_p  = csb_s[g];
                sclk_p = sclk_s[g];
            end
        end
    end

    task automatic wait_ready(input int d, output int unsigned t0);
        bit ok = 0;
        t0 = 0;
        for (int i = 0; i < 300; i++) begin
            if (cmd_ready_s[d]) begin
                ok = 1;
                t0 = cyc;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk(d, "ready_timeout", ok, 1);
    endtask

    task automatic wait_idle(input int d);
        bit ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (q[d].size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            chk(d, "done_timeout", ok, 1);
            q[d].delete();
        end
    endtask

    task automatic push_exp(input int d, input logic [15:0] frame, input logic [10:0] rd,
                            input int unsigned t0, input int unsigned lat, input bit is_ldb);
        exp_t e;
        e.frame = frame; e.rdata = rd; e.t0 = t0; e.lat = lat; e.is_ldb = is_ldb;
        q[d].push_back(e);
    endtask

    task automatic send(input int d, input logic rw, input logic [3:0] addr,
                        input logic [10:0] wdata, input bit push, input logic [15:0] frame,
                        input logic [10:0] rd, input int unsigned lat, output int unsigned t0);
        cmd_rw_s[d]    = rw;
        cmd_addr_s[d]  = addr;
        cmd_wdata_s[d] = wdata;
        cmd_valid_s[d] = 1'b1;
        wait_ready(d, t0);
        if (push) push_exp(d, frame, rd, t0, lat, 0);
        @(negedge clk);
        cmd_valid_s[d] = 1'b0;
    endtask

    task automatic ldb_pulse(input int d, input logic [10:0] rd);
        int unsigned t0;
        wait_ready(d, t0);
        ldb_valid_s[d] = 1'b1;
        push_exp(d, 16'h0000, rd, t0, 5, 1);
        @(negedge clk);
        ldb_valid_s[d] = 1'b0;
    endtask

    initial begin
        int unsigned t0, t1, dn;
        for (int d = 0; d < 2; d++) begin
            cmd_valid_s[d] = 0; cmd_rw_s[d] = 0; cmd_addr_s[d] = '0;
            cmd_wdata_s[d] = '0; ldb_valid_s[d] = 0; slave_w[d] = '0; dones[d] = 0;
        end

        // Reset held while inputs toggle
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                cmd_valid_s[d] = i[0]; ldb_valid_s[d] = i[1]; cmd_rw_s[d] = i[0];
                cmd_addr_s[d] = 4'(i); cmd_wdata_s[d] = 11'(i * 37);
            end
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk(d, "rst_csb", csb_s[d], 1);
            chk(d, "rst_ldb", ldb_s[d], 1);
            chk(d, "rst_sclk", sclk_s[d], 0);
            chk(d, "rst_mosi", mosi_s[d], 0);
            chk(d, "rst_done", done_s[d], 0);
            chk(d, "rst_rdata", rdata_s[d], 0);
            cmd_valid_s[d] = 0; ldb_valid_s[d] = 0;
        end
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) chk(d, "ready_after_rst", cmd_ready_s[d], 1);

        // Default timing: write, two reads, LDB, LDB with a pending write
        send(0, 1'b0, 4'd1, 11'h123, 1, 16'h0923, 11'h000, 69, t0);
        wait_idle(0);
        slave_w[0] = 11'h555;
        send(0, 1'b1, 4'd0, 11'h7FF, 1, 16'h8000, 11'h555, 69, t0);
        wait_idle(0);
        slave_w[0] = 11'h3AA;
        send(0, 1'b1, 4'd1, 11'h000, 1, 16'h8800, 11'h3AA, 69, t0);
        wait_idle(0);
        ldb_pulse(0, 11'h3AA);
        wait_idle(0);

        wait_ready(0, t0);
        cmd_rw_s[0] = 1'b0; cmd_addr_s[0] = 4'd2; cmd_wdata_s[0] = 11'h0AB;
        cmd_valid_s[0] = 1'b1; ldb_valid_s[0] = 1'b1;
        push_exp(0, 16'h0000, 11'h3AA, t0, 5, 1);
        @(negedge clk);
        ldb_valid_s[0] = 1'b0;
        wait_ready(0, t1);
        chk(0, "pending_cmd_accept", t1, t0 + 9);
        push_exp(0, 16'h10AB, 11'h3AA, t1, 69, 0);
        @(negedge clk);
        cmd_valid_s[0] = 1'b0;
        wait_idle(0);

        // Reset during bit 7 (bit 7 spans T0+31..T0+34): abort, no done
        send(0, 1'b0, 4'd4, 11'h155, 0, 16'h0000, 11'h000, 0, t0);
        while (cyc < t0 + 33) @(negedge clk);
        dn = dones[0];
        rst = 1'b1;
        #1;
        chk(0, "abort_csb", csb_s[0], 1);
        chk(0, "abort_sclk", sclk_s[0], 0);
        chk(0, "abort_mosi", mosi_s[0], 0);
        chk(0, "abort_ldb", ldb_s[0], 1);
        chk(0, "abort_rdata", rdata_s[0], 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (80) @(negedge clk);
        chk(0, "abort_no_done", dones[0] - dn, 0);
        send(0, 1'b0, 4'd15, 11'h7FF, 1, 16'h7FFF, 11'h000, 69, t0);
        wait_idle(0);

        // Fast timing: done latency 1 + 32 + 1 + 1 = 35
        send(1, 1'b0, 4'd5, 11'h2C3, 1, 16'h2AC3, 11'h000, 35, t0);
        wait_idle(1);
        slave_w[1] = 11'h6B5;
        send(1, 1'b1, 4'd3, 11'h001, 1, 16'h9800, 11'h6B5, 35, t0);
        wait_idle(1);
        ldb_pulse(1, 11'h6B5);
        wait_idle(1);

        repeat (10) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
